// File: rtl/aes_pkg.sv
// Shared encodings for the AES-128 round sequencer: FSM states, state-register
// source codes and stage enable indices.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ISSUE_ARK,
    ST_WAIT_ARK,
    ST_ISSUE_SBT,
    ST_WAIT_SBT,
    ST_ISSUE_SHR,
    ST_WAIT_SHR,
    ST_ISSUE_MXC,
    ST_WAIT_MXC,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SRC_PT     = 2'd0,
    SRC_ARK    = 2'd1,
    SRC_SBT    = 2'd2,
    SRC_SHRMXC = 2'd3
  } src_t;

  localparam int EN_ARK = 0;
  localparam int EN_SBT = 1;
  localparam int EN_SHR = 2;
  localparam int EN_MXC = 3;

  function automatic logic is_issue(input state_t s);
    return (s == ST_ISSUE_ARK) || (s == ST_ISSUE_SBT) ||
           (s == ST_ISSUE_SHR) || (s == ST_ISSUE_MXC);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == ST_WAIT_ARK) || (s == ST_WAIT_SBT) ||
           (s == ST_WAIT_SHR) || (s == ST_WAIT_MXC);
  endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// Loadable down-counter used as the per-stage response timeout.
// expire is the terminal-count compare (count at zero).
module aes_stage_timer #(
  parameter int W = 5
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: issues one-cycle stage enables, tracks the round
// index and steers/strobes the state register, with a per-stage timeout.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = NR_AES128,
  parameter int TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Abort,
  output logic       En_ARK,
  input  logic       Ry_ARK,
  output logic       En_SBT,
  input  logic       Ry_SBT,
  output logic       En_SHR,
  input  logic       Ry_SHR,
  output logic       En_MXC,
  input  logic       Ry_MXC,
  output logic [3:0] Round,
  output logic [1:0] Sel_Src,
  output logic       Ld_State,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Loaded on the ISSUE->WAIT edge so expiry lands TIMEOUT cycles after En_x rises.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 2);
  localparam logic [3:0]    LAST_RND = 4'(NR);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  src_t       sel_q, sel_d;
  logic [3:0] en_q, en_d;
  logic       ld_q, ld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ry_cur, tmo_expire;

  aes_stage_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (state_q == ST_IDLE),
    .load     (is_issue(state_q)),
    .load_val (TMO_LOAD),
    .dec      (is_wait(state_q)),
    .expire   (tmo_expire)
  );

  always_comb begin
    ry_cur = 1'b0;
    case (state_q)
      ST_WAIT_ARK: ry_cur = Ry_ARK;
      ST_WAIT_SBT: ry_cur = Ry_SBT;
      ST_WAIT_SHR: ry_cur = Ry_SHR;
      ST_WAIT_MXC: ry_cur = Ry_MXC;
      default:     ry_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    sel_d   = sel_q;
    err_d   = err_q;
    busy_d  = busy_q;
    en_d    = '0;
    ld_d    = 1'b0;
    done_d  = 1'b0;
    if (Abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (Start) begin
          state_d        = ST_ISSUE_ARK;
          en_d[EN_ARK]   = 1'b1;
          ld_d           = 1'b1;
          sel_d          = SRC_PT;
          busy_d         = 1'b1;
          err_d          = 1'b0;
          round_d        = '0;
        end
        ST_ISSUE_ARK: state_d = ST_WAIT_ARK;
        ST_ISSUE_SBT: state_d = ST_WAIT_SBT;
        ST_ISSUE_SHR: state_d = ST_WAIT_SHR;
        ST_ISSUE_MXC: state_d = ST_WAIT_MXC;
        ST_WAIT_ARK: if (ry_cur) begin
          ld_d  = 1'b1;
          sel_d = SRC_ARK;
          if (round_q == LAST_RND) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d      = ST_ISSUE_SBT;
            en_d[EN_SBT] = 1'b1;
            round_d      = round_q + 4'd1;
          end
        end
        ST_WAIT_SBT: if (ry_cur) begin
          ld_d         = 1'b1;
          sel_d        = SRC_SBT;
          state_d      = ST_ISSUE_SHR;
          en_d[EN_SHR] = 1'b1;
        end
        ST_WAIT_SHR: if (ry_cur) begin
          ld_d  = 1'b1;
          sel_d = SRC_SHRMXC;
          // The final round skips MixColumns.
          if (round_q == LAST_RND) begin
            state_d      = ST_ISSUE_ARK;
            en_d[EN_ARK] = 1'b1;
          end else begin
            state_d      = ST_ISSUE_MXC;
            en_d[EN_MXC] = 1'b1;
          end
        end
        ST_WAIT_MXC: if (ry_cur) begin
          ld_d         = 1'b1;
          sel_d        = SRC_SHRMXC;
          state_d      = ST_ISSUE_ARK;
          en_d[EN_ARK] = 1'b1;
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
      if (is_wait(state_q) && !ry_cur && tmo_expire) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      sel_q   <= SRC_PT;
      en_q    <= '0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign En_ARK   = en_q[EN_ARK];
  assign En_SBT   = en_q[EN_SBT];
  assign En_SHR   = en_q[EN_SHR];
  assign En_MXC   = en_q[EN_MXC];
  assign Round    = round_q;
  assign Sel_Src  = sel_q;
  assign Ld_State = ld_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: each Start pushes the expected run
// summary; a monitor builds the observed summary when Busy drops and compares.
module tb_aes_round_ctrl;

  logic       Clk;
  logic       Rst, Start, Abort;
  logic       Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC;
  logic       En_ARK, En_SBT, En_SHR, En_MXC;
  logic [3:0] Round;
  logic [1:0] Sel_Src;
  logic       Ld_State, Busy, Done, Err;

  aes_round_ctrl #(.NR(10), .TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
    .En_ARK(En_ARK), .Ry_ARK(Ry_ARK), .En_SBT(En_SBT), .Ry_SBT(Ry_SBT),
    .En_SHR(En_SHR), .Ry_SHR(Ry_SHR), .En_MXC(En_MXC), .Ry_MXC(Ry_MXC),
    .Round(Round), .Sel_Src(Sel_Src), .Ld_State(Ld_State),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  // term: 0 = Done, 1 = timeout Err, 2 = abort/reset
  typedef struct {
    int term; int cycles; int ark; int sbt; int shr; int mxc;
    int ld; int rmax; int err; int err_lat;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0, n_bad = 0, n_done = 0;
  int   dly[4];
  int   mute_round = -1;
  rec_t nominal;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({En_ARK, En_SBT, En_SHR, En_MXC, Round, Sel_Src,
                 Ld_State, Busy, Done, Err});
  endfunction

  // Stage models: Ry_x pulses dly[x] cycles after En_x; SHR can be muted in one round.
  initial begin
    int rem[4];
    logic [3:0] en_v, ry;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    forever begin
      @(posedge Clk); #1;
      en_v = {En_MXC, En_SHR, En_SBT, En_ARK};
      ry = '0;
      for (int i = 0; i < 4; i++) begin
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) ry[i] = 1'b1;
        end
        if (en_v[i]) rem[i] = (i == 2 && int'(Round) == mute_round) ? 0 : dly[i];
      end
      Ry_ARK = ry[0]; Ry_SBT = ry[1]; Ry_SHR = ry[2]; Ry_MXC = ry[3];
    end
  end

  // Monitor
  initial begin
    bit   act, ovl, rok;
    int   idx, st, last_en, ld, rmax, prevr;
    int   c[4];
    rec_t e;
    logic [3:0] ens;
    act = 0; idx = 0; st = 0; last_en = 0; ld = 0; rmax = 0; prevr = 0;
    ovl = 0; rok = 1;
    for (int i = 0; i < 4; i++) c[i] = 0;
    forever begin
      @(posedge Clk); #1;
      idx++;
      if (Done) n_done++;
      if (!act && Busy) begin
        act = 1; st = idx; ld = 0; rmax = 0; ovl = 0;
        for (int i = 0; i < 4; i++) c[i] = 0;
        prevr = int'(Round);
        rok = (Round == 4'd0);
      end
      if (act) begin
        ens = {En_MXC, En_SHR, En_SBT, En_ARK};
        if ($countones(ens) > 1) ovl = 1;
        for (int i = 0; i < 4; i++) if (ens[i]) c[i]++;
        if (ens != '0) last_en = idx;
        if (Ld_State) ld++;
        if (Busy && int'(Round) != prevr) begin
          if (int'(Round) != prevr + 1) rok = 0;
          prevr = int'(Round);
        end
        if (int'(Round) > rmax) rmax = int'(Round);
      end
      if (act && !Busy) begin
        act = 0;
        chk("exp_available", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("term", Done ? 0 : (Err ? 1 : 2), e.term);
          chk("cycles", idx - st, e.cycles);
          chk("ark_pulses", c[0], e.ark);
          chk("sbt_pulses", c[1], e.sbt);
          chk("shr_pulses", c[2], e.shr);
          chk("mxc_pulses", c[3], e.mxc);
          chk("ld_pulses", ld, e.ld);
          chk("round_max", rmax, e.rmax);
          chk("err", int'(Err), e.err);
          chk("en_overlap", int'(ovl), 0);
          chk("round_seq", int'(rok), 1);
          if (e.term == 1) chk("err_latency", idx - last_en, e.err_lat);
        end
      end
    end
  end

  task automatic run_start();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (Busy && n < limit);
    chk("idle_in_budget", int'(Busy), 0);
  endtask

  initial begin
    int n;
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0;
    Ry_ARK = 1'b0; Ry_SBT = 1'b0; Ry_SHR = 1'b0; Ry_MXC = 1'b0;
    for (int i = 0; i < 4; i++) dly[i] = 1;
    nominal = '{0, 80, 11, 10, 10, 9, 41, 10, 0, 0};
    #2 chk("reset_outputs", all_outs(), 0);
    #10 Rst = 1'b0;

    // nominal
    exp_q.push_back(nominal);
    run_start();
    wait_idle(200);

    // variable latency: SBT 5 cycles, MXC 3 cycles
    dly[1] = 5; dly[3] = 3;
    exp_q.push_back('{0, 138, 11, 10, 10, 9, 41, 10, 0, 0});
    run_start();
    wait_idle(300);
    dly[1] = 1; dly[3] = 1;

    // timeout: ShiftRows silent in round 3
    mute_round = 3;
    exp_q.push_back('{1, 36, 3, 3, 3, 2, 11, 3, 1, 16});
    run_start();
    wait_idle(200);
    mute_round = -1;
    repeat (3) @(posedge Clk);
    #1;
    chk("err_sticky", int'(Err), 1);
    chk("busy_after_tmo", int'(Busy), 0);

    // recovery run clears Err
    exp_q.push_back(nominal);
    run_start();
    wait_idle(200);

    // abort in WAIT_MXC of round 5 with Ry_MXC in the same cycle
    exp_q.push_back('{2, 40, 5, 5, 5, 5, 20, 5, 0, 0});
    run_start();
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!(En_MXC && Round == 4'd5) && n < 200);
    chk("reach_mxc_r5", int'(En_MXC && Round == 4'd5), 1);
    @(posedge Clk); #1 Abort = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0;
    chk("abort_quiet", int'({Busy, Ld_State, Done, En_ARK, En_SBT, En_SHR, En_MXC}), 0);
    wait_idle(10);

    // async reset during round 7
    exp_q.push_back('{2, 51, 7, 7, 6, 6, 26, 7, 0, 0});
    run_start();
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (Round != 4'd7 && n < 200);
    chk("reach_round7", int'(Round), 7);
    #3 Rst = 1'b1;
    #1 chk("reset_async", all_outs(), 0);
    #1 Rst = 1'b0;
    wait_idle(10);

    exp_q.push_back(nominal);
    run_start();
    wait_idle(200);

    // robustness: spurious Ry_ARK in WAIT_SBT, Start re-asserted while busy
    exp_q.push_back(nominal);
    run_start();
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!En_SBT && n < 50);
    chk("reach_sbt", int'(En_SBT), 1);
    @(posedge Clk); #2 Ry_ARK = 1'b1;
    Start = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Start = 1'b0;
    wait_idle(200);

    // Start and Abort together in IDLE: stays idle
    @(posedge Clk); #1 begin Start = 1'b1; Abort = 1'b1; end
    @(posedge Clk); #1 begin Start = 1'b0; Abort = 1'b0; end
    repeat (2) @(posedge Clk);
    #1 chk("start_abort_idle", int'({Busy, Ld_State, En_ARK}), 0);

    repeat (3) @(posedge Clk);
    #1;
    chk("runs_left", exp_q.size(), 0);
    chk("done_pulses", n_done, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption over the existing stage units: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Each stage has an En_x/Ry_x handshake.
- Drives the stage enables, the round index used by the key-schedule lookup, and the datapath state-register mux select.
- Reports completion, plus a timeout error if a stage never responds.

Parameters:
- NR, 10, number of AES rounds (final round omits MixColumns).
- TIMEOUT, 16, max cycles to wait for any Ry_x after its En_x pulse.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous reset, active-high
- Start  in  1  begin encryption; sampled only in IDLE
- Abort  in  1  synchronous abort; returns to IDLE next cycle
- En_ARK  out  1  AddRoundKey enable pulse
- Ry_ARK  in  1  AddRoundKey ready
- En_SBT  out  1  SubBytes enable pulse
- Ry_SBT  in  1  SubBytes ready
- En_SHR  out  1  ShiftRows enable pulse
- Ry_SHR  in  1  ShiftRows ready
- En_MXC  out  1  MixColumns enable pulse
- Ry_MXC  in  1  MixColumns ready
- Round  out  4  current round index 0..NR (round-key select)
- Sel_Src  out  2  state-register source: 0=plaintext, 1=ARK, 2=SBT, 3=SHR/MXC (last completed stage)
- Ld_State  out  1  one-cycle load strobe for the state register
- Busy  out  1  high from Start accept until Done/Err
- Done  out  1  one-cycle pulse, ciphertext valid in state register
- Err  out  1  sticky timeout flag; cleared by next accepted Start or Rst

Behaviour:
- Reset: all outputs 0; Round=0; FSM in IDLE; timeout counter 0.
- IDLE + Start=1:
  - Ld_State=1, Sel_Src=0, Busy=1, Err=0, Round=0.
  - Next state ISSUE_ARK.
- States: IDLE, ISSUE_ARK, WAIT_ARK, ISSUE_SBT, WAIT_SBT, ISSUE_SHR, WAIT_SHR, ISSUE_MXC, WAIT_MXC, FINISH.
- ISSUE_x:
  - Asserts En_x for exactly one cycle.
  - Clears the timeout counter.
  - Goes to WAIT_x.
- WAIT_x:
  - En_x=0. Counter increments each cycle.
  - Ry_x=1 → Ld_State=1 with the matching Sel_Src, then advance.
  - Ry_x sampled in the same cycle as En_x is ignored; a stage takes ≥1 cycle.
- Stage order:
  - Round 0: ARK only.
  - Rounds 1..NR-1: SBT→SHR→MXC→ARK.
  - Round NR: SBT→SHR→ARK.
- Round increments in the WAIT_ARK→ISSUE_SBT transition. After ARK with Round==NR, go to FINISH.
- Minimum latency with 1-cycle stages: 2 cycles per stage. Total 2*(1+4*(NR-1)+3)=80 cycles Start→Done for NR=10.
- FINISH: Done=1 for one cycle, Busy=0, then IDLE. Round holds NR until the next Start.
- Timeout: counter reaches TIMEOUT in any WAIT_x → Err=1, Busy=0, no Done, return to IDLE.
- Abort:
  - Any non-IDLE state → IDLE next cycle; all enables 0, Busy=0, no Done, Err unchanged.
  - Abort has priority over Ry_x and timeout in the same cycle.
- Start while Busy: ignored.
- Start and Abort together in IDLE: Abort wins, stays IDLE.
- Rst mid-operation: immediate return to reset values; in-flight stage result discarded, no Ld_State.
- Spurious Ry_x outside its WAIT_x: ignored.
- At most one En_x is high in any cycle.

Decomposition:
- Shared package aes_pkg: FSM state encoding, Sel_Src codes (SRC_PT, SRC_ARK, SRC_SBT, SRC_SHRMXC), NR_AES128=10.
- One sub-module: aes_stage_timer. Loadable down-counter with clear and expire outputs, reused for the timeout.

Test Plan:
- Nominal, 1-cycle ready on every stage:
  - Stimulus: Start.
  - Required: Done exactly 80 cycles after Start; 10 SBT pulses, 10 SHR pulses, 9 MXC pulses, 11 ARK pulses; Round sequence 0..10; Err=0.
- Variable latency:
  - Stimulus: Ry_SBT delayed 5 cycles, Ry_MXC delayed 3 cycles.
  - Required: Done at 80+9*(4+2)+4=138 cycles; ordering unchanged; never two En_x high at once.
- Timeout:
  - Stimulus: Ry_SHR never asserted in round 3.
  - Required: Err=1 exactly TIMEOUT cycles after En_SHR; Busy=0; Done never; a following Start clears Err and completes normally.
- Abort:
  - Stimulus: Abort in WAIT_MXC of round 5, with Ry_MXC high in the same cycle.
  - Required: IDLE next cycle; no Ld_State; Busy=0; no Done.
- Reset mid-run:
  - Stimulus: Rst pulse asynchronous to Clk during round 7.
  - Required: all outputs 0 immediately; Round=0; next Start runs the full 80-cycle sequence.
- Protocol robustness:
  - Stimulus: Start re-asserted while Busy; spurious Ry_ARK during WAIT_SBT.
  - Required: both ignored; sequence and Done timing identical to the nominal run.
